// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control and MDU sequencing
// for the 5-stage pipeline.
//
// Ports:
//   clk, rst             clock, sync active-high reset
//   id_rs/id_rt          ID source regs; id_use_rs/id_use_rt read flags
//   id_mdu_start/div/use ID MDU start, divide select, HI/LO use
//   id_branch_taken      branch resolved taken in ID
//   ex_wreg/m2reg/rd     EX writeback info
//   mem_wreg/m2reg/rd    MEM writeback info
//   dmem_req/dmem_ready  data-memory handshake (freeze source)
//   pc_we, if_id_we      front-end write enables
//   if_id_flush          nop into IF/ID
//   id_ex_bubble         nop control into ID/EX
//   pipe_we              ID/EX, EX/MEM, MEM/WB write enable
//   fwda, fwdb           EX operand selects
//   mdu_go/busy/done     MDU sequencing
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_mdu_start,
  input  logic       id_mdu_div,
  input  logic       id_mdu_use,
  input  logic       id_branch_taken,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rd,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_rd,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       pipe_we,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       mdu_go,
  output logic       mdu_busy,
  output logic       mdu_done
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nx;
  logic [5:0] cnt, cnt_nx;

  logic freeze, lu_stall, mdu_stall, stall, issue;
  logic hit_rs, hit_rt;

  assign freeze = dmem_req & ~dmem_ready;

  assign hit_rs = id_use_rs & (id_rs == ex_rd);
  assign hit_rt = id_use_rt & (id_rt == ex_rd);
  assign lu_stall = ex_wreg & ex_m2reg & (ex_rd != 5'd0)
                  & (hit_rs | hit_rt);

  assign mdu_busy  = (state == BUSY);
  assign mdu_stall = mdu_busy & id_mdu_use;
  assign stall     = lu_stall | mdu_stall;

  assign pc_we        = ~freeze & ~stall;
  assign if_id_we     = ~freeze & ~stall;
  assign id_ex_bubble = ~freeze & stall;
  assign pipe_we      = ~freeze;
  assign if_id_flush  = id_branch_taken & ~freeze & ~stall;

  assign issue  = ~freeze & ~stall & id_mdu_start;
  assign mdu_go = issue;

  // EX ALU result wins over MEM; an EX load never reaches here
  // because lu_stall holds the consumer back one cycle.
  always_comb begin
    fwda = 2'b00;
    if (id_use_rs && id_rs != 5'd0) begin
      if (ex_wreg && !ex_m2reg && ex_rd == id_rs)
        fwda = 2'b01;
      else if (mem_wreg && mem_rd == id_rs)
        fwda = mem_m2reg ? 2'b11 : 2'b10;
    end
  end

  always_comb begin
    fwdb = 2'b00;
    if (id_use_rt && id_rt != 5'd0) begin
      if (ex_wreg && !ex_m2reg && ex_rd == id_rt)
        fwdb = 2'b01;
      else if (mem_wreg && mem_rd == id_rt)
        fwdb = mem_m2reg ? 2'b11 : 2'b10;
    end
  end

  // The counter runs through freezes so the MDU finishes on
  // schedule regardless of memory wait states.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mdu_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_nx = BUSY;
          cnt_nx   = id_mdu_div ? DIV_LAST : MUL_LAST;
        end
      end
      BUSY: begin
        if (cnt != 6'd0) begin
          cnt_nx = cnt - 6'd1;
        end else begin
          mdu_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a cycle model of the
// hazard rules and literal spot checks.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt;
  logic       id_mdu_start, id_mdu_div, id_mdu_use;
  logic       id_branch_taken;
  logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic       dmem_req, dmem_ready;
  logic       pc_we, if_id_we, if_id_flush, id_ex_bubble;
  logic       pipe_we, mdu_go, mdu_busy, mdu_done;
  logic [1:0] fwda, fwdb;

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_div(id_mdu_div),
    .id_mdu_use(id_mdu_use),
    .id_branch_taken(id_branch_taken),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_we(pipe_we), .fwda(fwda), .fwdb(fwdb),
    .mdu_go(mdu_go), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: number of MDU busy cycles still to come, this one included.
  int busy_left = 0;

  function automatic logic [1:0] m_fwd(logic u, logic [4:0] r);
    if (!u || r == 5'd0) return 2'b00;
    if (ex_wreg && !ex_m2reg && ex_rd == r) return 2'b01;
    if (mem_wreg && mem_rd == r) return mem_m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_freeze();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit m_stall();
    bit lu;
    lu = ex_wreg && ex_m2reg && ex_rd != 0 &&
         ((id_use_rs && id_rs == ex_rd) ||
          (id_use_rt && id_rt == ex_rd));
    return lu || (busy_left > 0 && id_mdu_use);
  endfunction

  function automatic bit m_issue();
    return !m_freeze() && !m_stall() && id_mdu_start;
  endfunction

  always @(posedge clk) begin
    if (rst)
      busy_left <= 0;
    else if (busy_left > 0)
      busy_left <= busy_left - 1;
    else if (m_issue())
      busy_left <= id_mdu_div ? 32 : 4;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit f, s;
      f = m_freeze();
      s = m_stall();
      chk("pc_we",   pc_we,        !f && !s);
      chk("if_id_we", if_id_we,    !f && !s);
      chk("bubble",  id_ex_bubble, !f && s);
      chk("pipe_we", pipe_we,      !f);
      chk("flush",   if_id_flush,  id_branch_taken && !f && !s);
      chk("fwda",    fwda,         m_fwd(id_use_rs, id_rs));
      chk("fwdb",    fwdb,         m_fwd(id_use_rt, id_rt));
      chk("mdu_go",  mdu_go,       m_issue());
      chk("busy",    mdu_busy,     busy_left > 0);
      chk("done",    mdu_done,     busy_left == 1);
    end
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_use_rs = 0; id_use_rt = 0;
    id_mdu_start = 0; id_mdu_div = 0; id_mdu_use = 0;
    id_branch_taken = 0;
    ex_wreg = 0; ex_m2reg = 0; mem_wreg = 0; mem_m2reg = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  int nbusy;

  initial begin
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    mid();
    chk("rst_busy", mdu_busy, 1'b0);
    chk("rst_done", mdu_done, 1'b0);
    tick();

    // load-use: lw $2 in EX, add reads $2
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 2;
    id_rs = 2; id_use_rs = 1;
    mid();
    chk("lu_pc_we", pc_we, 1'b0);
    chk("lu_bubble", id_ex_bubble, 1'b1);
    tick();
    ex_wreg = 0; ex_m2reg = 0; ex_rd = 0;
    mem_wreg = 1; mem_m2reg = 1; mem_rd = 2;
    mid();
    chk("lu_fwda", fwda, 2'b11);
    chk("lu_pc_we2", pc_we, 1'b1);
    tick();

    // forwarding priority
    clr();
    ex_wreg = 1; ex_rd = 3; mem_wreg = 1; mem_rd = 3;
    id_rs = 3; id_use_rs = 1; id_rt = 3; id_use_rt = 1;
    mid();
    chk("fw_ex", fwda, 2'b01);
    chk("fw_ex_b", fwdb, 2'b01);
    tick();
    ex_wreg = 0;
    mid();
    chk("fw_mem", fwda, 2'b10);
    tick();
    ex_wreg = 1; ex_rd = 0; mem_rd = 0; id_rs = 0; id_rt = 0;
    mid();
    chk("fw_r0", fwda, 2'b00);
    tick();
    ex_rd = 7; mem_rd = 9; mem_m2reg = 1;
    id_rs = 7; id_rt = 9;
    tick();
    id_use_rt = 0;
    tick();

    // branch
    clr();
    id_branch_taken = 1;
    mid();
    chk("br_flush", if_id_flush, 1'b1);
    tick();
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5;
    id_rt = 5; id_use_rt = 1;
    mid();
    chk("br_st_flush", if_id_flush, 1'b0);
    chk("br_st_bub", id_ex_bubble, 1'b1);
    tick();

    // multiply, then mflo waits
    clr();
    id_mdu_start = 1; id_mdu_use = 1;
    mid();
    chk("mul_go", mdu_go, 1'b1);
    tick();
    id_mdu_start = 0;
    for (int k = 1; k <= 4; k++) begin
      mid();
      chk("mul_busy", mdu_busy, 1'b1);
      chk("mul_stall", pc_we, 1'b0);
      chk("mul_done", mdu_done, k == 4);
      tick();
    end
    mid();
    chk("mul_rel_busy", mdu_busy, 1'b0);
    chk("mul_rel_pc", pc_we, 1'b1);
    tick();

    // divide: count busy cycles
    clr();
    id_mdu_start = 1; id_mdu_use = 1; id_mdu_div = 1;
    tick();
    clr();
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      mid();
      if (mdu_busy) nbusy++;
      tick();
    end
    chk("div_cycles", nbusy, 32);

    // memory freeze during a multiply
    clr();
    id_mdu_start = 1; id_mdu_use = 1;
    tick();
    clr();
    dmem_req = 1;
    for (int k = 1; k <= 3; k++) begin
      mid();
      chk("frz_pc", pc_we, 1'b0);
      chk("frz_ifid", if_id_we, 1'b0);
      chk("frz_pipe", pipe_we, 1'b0);
      tick();
    end
    dmem_req = 0;
    mid();
    chk("frz_done", mdu_done, 1'b1);
    tick();
    dmem_req = 1; id_mdu_start = 1; id_mdu_use = 1;
    mid();
    chk("frz_nogo", mdu_go, 1'b0);
    tick();
    mid();
    chk("frz_nobusy", mdu_busy, 1'b0);
    dmem_ready = 1;
    tick();
    clr();
    tick();
    tick();
    tick();
    tick();

    // reset mid-divide at cnt=10
    clr();
    id_mdu_start = 1; id_mdu_div = 1; id_mdu_use = 1;
    tick();
    clr();
    for (int k = 0; k < 21; k++) tick();
    rst = 1;
    mid();
    chk("rst_mid_busy", mdu_busy, 1'b1);
    tick();
    rst = 0;
    id_mdu_start = 1; id_mdu_use = 1;
    mid();
    chk("rst_abort", mdu_busy, 1'b0);
    chk("rst_go", mdu_go, 1'b1);
    tick();
    clr();
    mid();
    chk("rst_rebusy", mdu_busy, 1'b1);
    for (int k = 0; k < 6; k++) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined CPU. It drives the write enables, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and generates the EX-stage forwarding selects. It also owns the multi-cycle multiply/divide unit (MDU) busy sequencing and freezes the whole pipeline during data-memory wait states. It sits beside the ID stage and takes register numbers and control bits from ID, EX and MEM.

## Interface
- MUL_CYCLES, 4, MDU busy cycles for a multiply (≥1)
- DIV_CYCLES, 32, MDU busy cycles for a divide (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5  source register numbers of the ID instruction
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- id_mdu_start  in  1  ID instruction starts an MDU op
- id_mdu_div  in  1  1 = divide, 0 = multiply (valid with id_mdu_start)
- id_mdu_use  in  1  ID instruction reads HI/LO or starts an MDU op
- id_branch_taken  in  1  branch/jump resolved taken in ID
- ex_wreg, ex_m2reg  in  1  EX instruction writes a register / is a load
- ex_rd  in  5  EX destination register
- mem_wreg, mem_m2reg  in  1  MEM instruction writes a register / is a load
- mem_rd  in  5  MEM destination register
- dmem_req, dmem_ready  in  1  MEM-stage access pending / memory done
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  load zero (nop) into IF/ID at next edge
- id_ex_bubble  out  1  load nop control into ID/EX at next edge
- pipe_we  out  1  ID/EX, EX/MEM, MEM/WB write enable
- fwda, fwdb  out  2  EX operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- mdu_go  out  1  one-cycle MDU start pulse
- mdu_busy  out  1  MDU sequencing active
- mdu_done  out  1  last busy cycle

## Operation
- freeze = dmem_req & !dmem_ready. While frozen: pc_we = if_id_we = pipe_we = 0, no flush, no bubble, no mdu_go.
- lu_stall = ex_wreg & ex_m2reg & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- mdu_stall = mdu_busy & id_mdu_use.
- stall = lu_stall | mdu_stall. pc_we = if_id_we = !freeze & !stall. id_ex_bubble = !freeze & stall. pipe_we = !freeze.
- if_id_flush = id_branch_taken & !freeze & !stall. A stalled branch does not flush; it re-resolves when it advances.
- issue = !freeze & !stall & id_mdu_start. mdu_go = issue (combinational).
- Forwarding (fwda on id_rs/id_use_rs, fwdb on id_rt/id_use_rt; register 0 is never forwarded):
  - If EX writes the register and EX is not a load: 01.
  - Else if MEM writes the register: 11 if mem_m2reg, else 10.
  - Else: 00.
  - EX has priority over MEM. The EX-load case is covered by lu_stall.
- State machine IDLE/BUSY with a 6-bit down-counter cnt:
  - IDLE, issue: go to BUSY, cnt = (div ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY, cnt≠0: decrement cnt.
  - BUSY, cnt==0: mdu_done = 1, go to IDLE.
  - cnt keeps counting during freeze.
  - mdu_busy = (state==BUSY).
  - issue cannot occur in BUSY, because id_mdu_start implies id_mdu_use and therefore mdu_stall.
- Reset:
  - state = IDLE, cnt = 0, so mdu_busy = mdu_done = 0.
  - Reset during BUSY aborts the op.
  - Combinational outputs follow the inputs from the first cycle after reset.

## Timing
- Stall/flush/forward outputs are combinational and take effect at the next rising edge.
- Load-use: exactly 1 stall cycle. The load then sits in MEM, and forwarding selects 11.
- MDU issued in cycle T: mdu_busy is high for cycles T+1 … T+N (N = MUL_CYCLES or DIV_CYCLES), with mdu_done high in T+N. A dependent ID instruction stalls through T+N and advances at the edge ending T+N+1's predecessor, i.e. it is issued in T+N+1.
- Freeze has priority over stall and flush. Stall has priority over flush.

## Test plan
- Load-use: lw $2 in EX (ex_rd=2, m2reg), ID add reads rs=2 → 1 cycle with pc_we=0, id_ex_bubble=1; next cycle fwda=11, pc_we=1.
- Forwarding: EX ALU writes $3, MEM ALU writes $3, ID reads rs=3 → fwda=01. Same case with ex_wreg=0 → fwda=10. rd=0 in both stages → fwda=00.
- Branch: id_branch_taken=1, no hazard → if_id_flush=1 for 1 cycle. Same with lu_stall active → if_id_flush=0, stall asserted.
- Multiply with MUL_CYCLES=4: mdu_go pulse in T; mdu_busy high for 4 cycles, mdu_done in T+4; mflo in ID stalls 4 cycles and issues in T+5. A divide gives 32 busy cycles.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles during an MDU op → pc_we, if_id_we, pipe_we all 0 for those 3 cycles. The MDU counter still reaches done on schedule, and no mdu_go is issued during freeze.
- Reset asserted mid-BUSY (cnt=10) → next cycle mdu_busy=0 and state IDLE; a new mdu_start is accepted immediately.
